// File: rtl/demux1to4_tdm.sv
// Time-division 1-to-4 demultiplexer: routes sof-framed slot beats 0..3 onto lanes A..D.
// Optional DEMUX1TO4_ERR_CNT_EN adds a saturating err_cnt output.
module demux1to4_tdm #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    input  logic             sof,
    output logic             din_ready,
    output logic [1:0]       sel,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] C,
    output logic [WIDTH-1:0] D,
    output logic             frame_valid,
    input  logic             frame_ready,
    output logic             frame_err
`ifdef DEMUX1TO4_ERR_CNT_EN
    ,
    output logic [7:0]       err_cnt
`endif
);

    typedef enum logic {IDLE, FILL} state_t;

    state_t           state, state_n;
    logic [1:0]       sel_n;
    logic [WIDTH-1:0] s0, s1, s2, s0_n, s1_n, s2_n;
    logic [WIDTH-1:0] a_n, b_n, c_n, d_n;
    logic             fv_n, err_n;
    logic             accept, take, drop;

    // Only the final slot stalls, and only while a held frame is not being taken.
    assign din_ready = rst | ~((sel == 2'd3) & frame_valid & ~frame_ready);
    assign accept    = din_valid & din_ready;
    assign take      = frame_valid & frame_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            sel         <= '0;
            s0          <= '0;
            s1          <= '0;
            s2          <= '0;
            A           <= '0;
            B           <= '0;
            C           <= '0;
            D           <= '0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            state       <= state_n;
            sel         <= sel_n;
            s0          <= s0_n;
            s1          <= s1_n;
            s2          <= s2_n;
            A           <= a_n;
            B           <= b_n;
            C           <= c_n;
            D           <= d_n;
            frame_valid <= fv_n;
            frame_err   <= err_n;
        end
    end

    always_comb begin
        state_n = state;
        sel_n   = sel;
        s0_n    = s0;
        s1_n    = s1;
        s2_n    = s2;
        a_n     = A;
        b_n     = B;
        c_n     = C;
        d_n     = D;
        fv_n    = frame_valid & ~take;
        err_n   = 1'b0;
        drop    = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept && sof) begin
                    s0_n    = din;
                    sel_n   = 2'd1;
                    state_n = FILL;
                end else if (accept) begin
                    drop = 1'b1;
                end
            end
            FILL: begin
                if (accept && sof) begin
                    err_n = 1'b1;
                    s0_n  = din;
                    sel_n = 2'd1;
                end else if (accept && sel == 2'd3) begin
                    // A completion can only be accepted when the held frame is empty or being taken.
                    a_n     = s0;
                    b_n     = s1;
                    c_n     = s2;
                    d_n     = din;
                    fv_n    = 1'b1;
                    sel_n   = '0;
                    state_n = IDLE;
                end else if (accept) begin
                    if (sel == 2'd1) s1_n = din;
                    else             s2_n = din;
                    sel_n = sel + 2'd1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

`ifdef DEMUX1TO4_ERR_CNT_EN
    always_ff @(posedge clk) begin
        if (rst)
            err_cnt <= '0;
        else if ((err_n || drop) && err_cnt != 8'hFF)
            err_cnt <= err_cnt + 8'd1;
    end
`endif

endmodule

// File: tb/tb_demux1to4_tdm.sv
// Directed self-checking bench for demux1to4_tdm with WIDTH=4.
module tb_demux1to4_tdm;

    logic       clk = 1'b0;
    logic       rst, din_valid, sof, frame_ready;
    logic [3:0] din;
    logic       din_ready, frame_valid, frame_err;
    logic [1:0] sel;
    logic [3:0] A, B, C, D;
`ifdef DEMUX1TO4_ERR_CNT_EN
    logic [7:0] err_cnt;
`endif
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    demux1to4_tdm #(.WIDTH(4)) dut (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .sof(sof),
        .din_ready(din_ready), .sel(sel), .A(A), .B(B), .C(C), .D(D),
        .frame_valid(frame_valid), .frame_ready(frame_ready), .frame_err(frame_err)
`ifdef DEMUX1TO4_ERR_CNT_EN
        , .err_cnt(err_cnt)
`endif
    );

    // Drive one cycle of input, then settle just after the active edge.
    task automatic beat(input logic v, input logic s, input logic [3:0] d);
        din_valid = v; sof = s; din = d;
        @(posedge clk); #1;
        din_valid = 1'b0; sof = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; din_valid = 1'b0; sof = 1'b0; din = '0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        frame_ready = 1'b1;
        do_reset();
        total++; if ({A, B, C, D} !== 16'h0000) begin bad++; $display("FAIL reset_lanes got=%h exp=0000", {A, B, C, D}); end
        total++; if (frame_valid !== 1'b0) begin bad++; $display("FAIL reset_fv got=%b exp=0", frame_valid); end
        total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", frame_err); end
        total++; if (sel !== 2'd0) begin bad++; $display("FAIL reset_sel got=%0d exp=0", sel); end
        total++; if (din_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", din_ready); end
`ifdef DEMUX1TO4_ERR_CNT_EN
        total++; if (err_cnt !== 8'd0) begin bad++; $display("FAIL reset_errcnt got=%0d exp=0", err_cnt); end
`endif
    endtask

    task automatic test_basic();
        logic [3:0] vals [4] = '{4'h1, 4'h2, 4'h3, 4'h4};
        logic [1:0] exp_sel [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
        frame_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            beat(1'b1, i == 0, vals[i]);
            total++; if (sel !== exp_sel[i]) begin bad++; $display("FAIL basic_sel%0d got=%0d exp=%0d", i, sel, exp_sel[i]); end
            total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL basic_err%0d got=%b exp=0", i, frame_err); end
        end
        total++; if (frame_valid !== 1'b1) begin bad++; $display("FAIL basic_fv got=%b exp=1", frame_valid); end
        total++; if ({A, B, C, D} !== 16'h1234) begin bad++; $display("FAIL basic_lanes got=%h exp=1234", {A, B, C, D}); end
        beat(1'b0, 1'b0, 4'h0);
        total++; if (frame_valid !== 1'b0) begin bad++; $display("FAIL basic_fv_taken got=%b exp=0", frame_valid); end
        total++; if ({A, B, C, D} !== 16'h1234) begin bad++; $display("FAIL basic_hold got=%h exp=1234", {A, B, C, D}); end
    endtask

    task automatic test_backpressure();
        frame_ready = 1'b0;
        beat(1'b1, 1'b1, 4'h1); beat(1'b1, 1'b0, 4'h2); beat(1'b1, 1'b0, 4'h3); beat(1'b1, 1'b0, 4'h4);
        total++; if (frame_valid !== 1'b1) begin bad++; $display("FAIL bp_fv1 got=%b exp=1", frame_valid); end
        beat(1'b1, 1'b1, 4'h5); beat(1'b1, 1'b0, 4'h6); beat(1'b1, 1'b0, 4'h7);
        total++; if (sel !== 2'd3) begin bad++; $display("FAIL bp_sel got=%0d exp=3", sel); end
        din_valid = 1'b1; din = 4'h8; #1;
        total++; if (din_ready !== 1'b0) begin bad++; $display("FAIL bp_stall_ready got=%b exp=0", din_ready); end
        beat(1'b1, 1'b0, 4'h8);
        total++; if (sel !== 2'd3) begin bad++; $display("FAIL bp_sel_stalled got=%0d exp=3", sel); end
        total++; if ({A, B, C, D} !== 16'h1234) begin bad++; $display("FAIL bp_hold got=%h exp=1234", {A, B, C, D}); end
        frame_ready = 1'b1; din_valid = 1'b1; din = 4'h8; #1;
        total++; if (din_ready !== 1'b1) begin bad++; $display("FAIL bp_release_ready got=%b exp=1", din_ready); end
        beat(1'b1, 1'b0, 4'h8);
        total++; if ({A, B, C, D} !== 16'h5678) begin bad++; $display("FAIL bp_lanes2 got=%h exp=5678", {A, B, C, D}); end
        total++; if (frame_valid !== 1'b1) begin bad++; $display("FAIL bp_fv_stay got=%b exp=1", frame_valid); end
        beat(1'b0, 1'b0, 4'h0);
        total++; if (frame_valid !== 1'b0) begin bad++; $display("FAIL bp_fv_clear got=%b exp=0", frame_valid); end
    endtask

    task automatic test_mid_sof();
        frame_ready = 1'b1;
        beat(1'b1, 1'b1, 4'hA); beat(1'b1, 1'b0, 4'hB);
        beat(1'b1, 1'b1, 4'hC);
        total++; if (frame_err !== 1'b1) begin bad++; $display("FAIL midsof_err got=%b exp=1", frame_err); end
        total++; if (sel !== 2'd1) begin bad++; $display("FAIL midsof_sel got=%0d exp=1", sel); end
        beat(1'b1, 1'b0, 4'hD);
        total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL midsof_err_clr got=%b exp=0", frame_err); end
        beat(1'b1, 1'b0, 4'hE); beat(1'b1, 1'b0, 4'hF);
        total++; if ({A, B, C, D} !== 16'hCDEF) begin bad++; $display("FAIL midsof_lanes got=%h exp=cdef", {A, B, C, D}); end
        total++; if (frame_valid !== 1'b1) begin bad++; $display("FAIL midsof_fv got=%b exp=1", frame_valid); end
        beat(1'b0, 1'b0, 4'h0);
    endtask

    task automatic test_back_to_back_err();
        beat(1'b1, 1'b1, 4'h1);
        beat(1'b1, 1'b1, 4'h2);
        total++; if (frame_err !== 1'b1) begin bad++; $display("FAIL b2b_err1 got=%b exp=1", frame_err); end
        beat(1'b1, 1'b1, 4'h3);
        total++; if (frame_err !== 1'b1) begin bad++; $display("FAIL b2b_err2 got=%b exp=1", frame_err); end
        beat(1'b0, 1'b0, 4'h0);
        total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL b2b_err_clr got=%b exp=0", frame_err); end
    endtask

    task automatic test_idle_garbage();
        frame_ready = 1'b1;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            beat(1'b1, 1'b0, 4'h7);
            total++; if (sel !== 2'd0 || frame_valid !== 1'b0) begin
                bad++; $display("FAIL garbage%0d sel=%0d fv=%b exp sel=0 fv=0", i, sel, frame_valid); end
        end
        beat(1'b1, 1'b1, 4'h9); beat(1'b1, 1'b0, 4'hA); beat(1'b1, 1'b0, 4'hB); beat(1'b1, 1'b0, 4'hC);
        total++; if ({A, B, C, D} !== 16'h9ABC || frame_valid !== 1'b1) begin
            bad++; $display("FAIL garbage_frame got=%h fv=%b exp=9abc fv=1", {A, B, C, D}, frame_valid); end
`ifdef DEMUX1TO4_ERR_CNT_EN
        total++; if (err_cnt !== 8'd3) begin bad++; $display("FAIL garbage_errcnt got=%0d exp=3", err_cnt); end
`endif
        beat(1'b0, 1'b0, 4'h0);
    endtask

    task automatic test_reset_mid();
        frame_ready = 1'b0;
        beat(1'b1, 1'b1, 4'h1); beat(1'b1, 1'b0, 4'h2); beat(1'b1, 1'b0, 4'h3); beat(1'b1, 1'b0, 4'h4);
        beat(1'b1, 1'b1, 4'h5); beat(1'b1, 1'b0, 4'h6); beat(1'b1, 1'b0, 4'h7);
        do_reset();
        total++; if (sel !== 2'd0 || frame_valid !== 1'b0 || {A, B, C, D} !== 16'h0000) begin
            bad++; $display("FAIL rstmid sel=%0d fv=%b lanes=%h exp 0/0/0000", sel, frame_valid, {A, B, C, D}); end
        beat(1'b1, 1'b0, 4'h8);
        total++; if (sel !== 2'd0) begin bad++; $display("FAIL rstmid_drop got=%0d exp=0", sel); end
        frame_ready = 1'b1;
    endtask

    task automatic test_gaps();
        logic [3:0] vals [4] = '{4'h3, 4'h1, 4'h4, 4'h1};
        frame_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            beat(1'b1, i == 0, vals[i]);
            if (i < 3) begin
                beat(1'b0, 1'b1, 4'hF);
                total++; if (sel !== 2'(i + 1)) begin bad++; $display("FAIL gap_sel%0d got=%0d exp=%0d", i, sel, i + 1); end
            end
        end
        total++; if ({A, B, C, D} !== 16'h3141 || frame_valid !== 1'b1) begin
            bad++; $display("FAIL gap_frame got=%h fv=%b exp=3141 fv=1", {A, B, C, D}, frame_valid); end
        beat(1'b0, 1'b0, 4'h0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_mid_sof();
        test_back_to_back_err();
        test_idle_garbage();
        test_reset_mid();
        test_gaps();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
